// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory responder.
//   state_e    : responder FSM states
//   WORD_BYTES : bytes per instruction word
//   addr_ok()  : alignment + range check used by the fetch and load paths
package imem_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CNT_W      = 4;   // holds LATENCY-1 for LATENCY <= 15

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // True when addr is word aligned and inside the array; checked at full
  // 64-bit width so that high PC bits can never alias into the array.
  function automatic logic addr_ok(input logic [63:0] addr,
                                   input logic [63:0] depth_words);
    logic [63:0] limit;
    limit = depth_words * 64'(WORD_BYTES);
    return ((addr % 64'(WORD_BYTES)) == 64'd0) && (addr < limit);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH_WORDS x 32 instruction storage.
//   wr_en_i/wr_addr_i/wr_data_i : synchronous write port
//   rd_en_i/rd_addr_i           : read sampled on the edge where rd_en_i=1
//   rd_clr_i                    : force the read result to zero (faulted fetch)
//   rd_data_o                   : registered read data, read-before-write
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_clr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Same-edge write is not visible here: mem_q still holds the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_o <= 32'd0;
    end else if (rd_en_i) begin
      rd_data_o <= rd_clr_i ? 32'd0 : mem_q[rd_addr_i];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for PC fetches.
//   req_valid/req_ready/req_addr : one 64-bit byte-address fetch per handshake
//   rsp_valid/rsp_ready          : response handshake, held until accepted
//   rsp_data/rsp_err             : instruction word, or 0 with err on a fault
//   load_en/load_addr/load_data  : program-image write port, any state
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [AW-1:0]    idx_q;
  logic             err_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;

  logic             req_fire;
  logic             err_now;
  logic             enter_resp;
  logic             rd_clr;
  logic [AW-1:0]    rd_idx;
  logic             wr_ok;

  assign req_fire = req_valid && req_ready_q;
  assign err_now  = !addr_ok(req_addr, 64'(DEPTH_WORDS));

  // With zero latency the accepting edge is also the RESP-entry edge, so the
  // read must use the live request rather than the latched copy.
  assign enter_resp = (req_fire && (LATENCY == 0)) ||
                      ((state_q == WAIT) && (cnt_q == '0));
  assign rd_idx     = (state_q == IDLE) ? req_addr[AW+1:2] : idx_q;
  assign rd_clr     = (state_q == IDLE) ? err_now : err_q;
  assign wr_ok      = load_en && addr_ok(load_addr, 64'(DEPTH_WORDS));

  // Request/response FSM with wait-state counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (enter_resp) rsp_err_q <= rd_clr;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            idx_q       <= req_addr[AW+1:2];
            err_q       <= err_now;
            req_ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_ok),
    .wr_addr_i (load_addr[AW+1:2]),
    .wr_data_i (load_data),
    .rd_en_i   (enter_resp),
    .rd_clr_i  (rd_clr),
    .rd_addr_i (rd_idx),
    .rd_data_o (rsp_data)
  );

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;

endmodule
